// File: rtl/permutation_job_controller.sv
// permutation_job_controller
// Sequences one job on fullPermutationPipeline30: pulse the top transmitter,
// wait for it to finish plus a settle time, stream N bots under almostFull and
// credit back-pressure, then wait for all N results before pulsing job_done.
// Optional build macro: PERM_JOB_ACCUM_EN adds per-job coefficient sum/count
// accumulators (pcoeff_sum/pcoeff_count in, job_sum/job_count out).
module permutation_job_controller #(
    parameter int unsigned COUNT_W         = 16,
    parameter int unsigned MAX_OUTSTANDING = 512,
    parameter int unsigned TOP_SETTLE      = 8
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               job_start,
    input  logic [COUNT_W-1:0] job_bots,
    output logic               job_ready,
    output logic               top_transmit,
    input  logic               top_done,
    input  logic               bot_valid,
    output logic               bot_ready,
    output logic               pipe_write,
    input  logic               pipe_almost_full,
    input  logic               pipe_result,
    input  logic               sink_ready,
    output logic               pipe_slow_down,
    output logic [COUNT_W-1:0] outstanding,
    output logic               job_done,
    output logic               error
`ifdef PERM_JOB_ACCUM_EN
    ,
    input  logic [47:0]        pcoeff_sum,
    input  logic [12:0]        pcoeff_count,
    output logic [63:0]        job_sum,
    output logic [31:0]        job_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_TOP,
        S_WAIT_TOP,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int unsigned SETTLE_W = $clog2(TOP_SETTLE + 1) + 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        SETTLE_W'((TOP_SETTLE == 0) ? 0 : TOP_SETTLE - 1);
    localparam logic [31:0] MAX_OUT_L = 32'(MAX_OUTSTANDING);

    state_t               r_state;
    state_t               w_next_state;
    logic [COUNT_W-1:0]   r_job_bots;
    logic [COUNT_W-1:0]   r_remaining;
    logic [COUNT_W-1:0]   r_outstanding;
    logic [COUNT_W-1:0]   r_results_seen;
    logic [SETTLE_W-1:0]  r_settle;
    logic                 r_top_seen;
    logic                 r_error;

    logic                 w_credit;
    logic                 w_write;
    logic                 w_result_ok;
    logic                 w_result_err;
    logic                 w_settle_done;
    logic                 w_start;

    // Datapath qualifiers: write enable, result legality and settle completion
    always_comb begin
        w_credit      = (32'(r_outstanding) < MAX_OUT_L);
        w_write       = (r_state == S_STREAM) && bot_valid && !pipe_almost_full &&
                        w_credit && (r_remaining != '0);
        w_result_ok   = pipe_result && ((r_state == S_STREAM) || (r_state == S_DRAIN)) &&
                        (r_outstanding != '0);
        w_result_err  = pipe_result && !w_result_ok;
        w_start       = (r_state == S_IDLE) && job_start;
        // A zero settle time hands over to STREAM on the same cycle top_done is seen
        if (TOP_SETTLE == 0) begin
            w_settle_done = top_done;
        end else begin
            w_settle_done = r_top_seen && (r_settle == SETTLE_LAST);
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_next_state = r_state;
        job_ready    = 1'b0;
        top_transmit = 1'b0;
        job_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_start) begin
                    w_next_state = (job_bots == '0) ? S_DONE : S_SEND_TOP;
                end
            end
            S_SEND_TOP: begin
                top_transmit = 1'b1;
                w_next_state = S_WAIT_TOP;
            end
            S_WAIT_TOP: begin
                if (w_settle_done) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_write && (r_remaining == COUNT_W'(1))) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_results_seen == r_job_bots) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                job_done     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Job counters, settle timer and sticky error flag
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_job_bots     <= '0;
            r_remaining    <= '0;
            r_outstanding  <= '0;
            r_results_seen <= '0;
            r_settle       <= '0;
            r_top_seen     <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            if (w_start) begin
                r_job_bots     <= job_bots;
                r_remaining    <= job_bots;
                r_results_seen <= '0;
            end
            if (r_state == S_SEND_TOP) begin
                r_top_seen <= 1'b0;
                r_settle   <= '0;
            end
            if (r_state == S_WAIT_TOP) begin
                if (!r_top_seen) begin
                    r_top_seen <= top_done;
                end else begin
                    r_settle <= r_settle + SETTLE_W'(1);
                end
            end
            if (w_write) begin
                r_remaining <= r_remaining - COUNT_W'(1);
            end
            case ({w_write, w_result_ok})
                2'b10:   r_outstanding <= r_outstanding + COUNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - COUNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_result_ok) begin
                r_results_seen <= r_results_seen + COUNT_W'(1);
            end
            if (w_result_err) begin
                r_error <= 1'b1;
            end
        end
    end

`ifdef PERM_JOB_ACCUM_EN
    logic [63:0] r_job_sum;
    logic [31:0] r_job_count;

    // Per-job accumulation of accepted results; cleared when a top is about to be sent
    always_ff @(posedge clock) begin
        if (!rst) begin
            r_job_sum   <= '0;
            r_job_count <= '0;
        end else if (w_start && (job_bots != '0)) begin
            r_job_sum   <= '0;
            r_job_count <= '0;
        end else if (w_result_ok) begin
            r_job_sum   <= r_job_sum + {16'd0, pcoeff_sum};
            r_job_count <= r_job_count + {19'd0, pcoeff_count};
        end
    end

    assign job_sum   = r_job_sum;
    assign job_count = r_job_count;
`endif

    assign bot_ready      = w_write;
    assign pipe_write     = w_write;
    assign pipe_slow_down = !sink_ready;
    assign outstanding    = r_outstanding;
    assign error          = r_error;

endmodule

// File: tb/tb_permutation_job_controller.sv
// Testbench for permutation_job_controller: table-driven job scenarios,
// hand-written credit/error sequences and a randomized phase, all checked
// cycle by cycle against a timestamp-based reference model.
module tb_permutation_job_controller;

    localparam int COUNT_W = 16;
    localparam int MAXO    = 4;
    localparam int SETTLE  = 8;

    logic               clock;
    logic               rst;
    logic               job_start;
    logic [COUNT_W-1:0] job_bots;
    logic               job_ready;
    logic               top_transmit;
    logic               top_done;
    logic               bot_valid;
    logic               bot_ready;
    logic               pipe_write;
    logic               pipe_almost_full;
    logic               pipe_result;
    logic               sink_ready;
    logic               pipe_slow_down;
    logic [COUNT_W-1:0] outstanding;
    logic               job_done;
    logic               error;
`ifdef PERM_JOB_ACCUM_EN
    logic [47:0]        pcoeff_sum;
    logic [12:0]        pcoeff_count;
    logic [63:0]        job_sum;
    logic [31:0]        job_count;
`endif

    permutation_job_controller #(
        .COUNT_W(COUNT_W),
        .MAX_OUTSTANDING(MAXO),
        .TOP_SETTLE(SETTLE)
    ) dut (
        .clock(clock),
        .rst(rst),
        .job_start(job_start),
        .job_bots(job_bots),
        .job_ready(job_ready),
        .top_transmit(top_transmit),
        .top_done(top_done),
        .bot_valid(bot_valid),
        .bot_ready(bot_ready),
        .pipe_write(pipe_write),
        .pipe_almost_full(pipe_almost_full),
        .pipe_result(pipe_result),
        .sink_ready(sink_ready),
        .pipe_slow_down(pipe_slow_down),
        .outstanding(outstanding),
        .job_done(job_done),
        .error(error)
`ifdef PERM_JOB_ACCUM_EN
        ,
        .pcoeff_sum(pcoeff_sum),
        .pcoeff_count(pcoeff_count),
        .job_sum(job_sum),
        .job_count(job_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int tcyc = 0;
    bit chk_en = 0;

    // reference model: job described by timestamps and write/result tallies
    bit m_active, m_tseen, m_err;
    int m_s, m_n, m_w, m_r, m_tdone, m_tlast;
    logic [63:0] m_sum;
    logic [31:0] m_cnt;

    // per-scenario observations
    int row_w, row_fw, row_afw, row_top, row_done, row_td;
    logic [63:0] done_sum;
    logic [31:0] done_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, tcyc);
        end
    endtask

    task automatic model_cycle();
        bit e_ready, e_top, e_write, e_done, res_ok;
        int m_out;
        m_out   = m_w - m_r;
        e_ready = !m_active;
        e_top   = m_active && (m_n > 0) && (tcyc == m_s + 1);
        e_write = m_active && (m_n > 0) && m_tseen && (tcyc >= m_tdone + SETTLE + 1) &&
                  (m_w < m_n) && bot_valid && !pipe_almost_full && (m_out < MAXO);
        e_done  = m_active && (((m_n == 0) && (tcyc == m_s + 1)) ||
                               ((m_n > 0) && (m_r == m_n) && (tcyc == m_tlast + 2)));
        if (chk_en) begin
            check("job_ready", job_ready, e_ready);
            check("top_transmit", top_transmit, e_top);
            check("pipe_write", pipe_write, e_write);
            check("bot_ready", bot_ready, e_write);
            check("outstanding", outstanding, 64'(m_out));
            check("job_done", job_done, e_done);
            check("error", error, m_err);
            check("pipe_slow_down", pipe_slow_down, !sink_ready);
`ifdef PERM_JOB_ACCUM_EN
            check("job_sum", job_sum, m_sum);
            check("job_count", job_count, m_cnt);
`endif
        end
        if (!rst) begin
            m_active = 0; m_w = 0; m_r = 0; m_err = 0; m_tseen = 0;
            m_sum = '0; m_cnt = '0;
        end else begin
            res_ok = pipe_result && (m_out > 0);
            if (pipe_result && !res_ok) m_err = 1;
            if (res_ok) begin
                m_r++;
`ifdef PERM_JOB_ACCUM_EN
                m_sum = m_sum + 64'(pcoeff_sum);
                m_cnt = m_cnt + 32'(pcoeff_count);
`endif
                if (m_r == m_n) m_tlast = tcyc;
            end
            if (e_write) m_w++;
            if (m_active && (m_n > 0) && !m_tseen && (tcyc >= m_s + 2) && top_done) begin
                m_tseen = 1;
                m_tdone = tcyc;
            end
            if (e_done) begin
                m_active = 0;
            end else if (!m_active && job_start) begin
                m_active = 1; m_s = tcyc; m_n = int'(job_bots);
                m_w = 0; m_r = 0; m_tseen = 0;
                if (m_n > 0) begin
                    m_sum = '0; m_cnt = '0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        model_cycle();
        if (pipe_write) begin
            if (row_fw < 0) row_fw = tcyc;
            row_w++;
            if (pipe_almost_full) row_afw++;
        end
        if (top_transmit) row_top++;
        if (job_done) begin
            row_done++;
`ifdef PERM_JOB_ACCUM_EN
            done_sum = job_sum;
            done_cnt = job_count;
`endif
        end
        tcyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_row();
        row_w = 0; row_fw = -1; row_afw = 0; row_top = 0; row_done = 0; row_td = -1;
    endtask

    task automatic start_job(input int n);
        job_start = 1'b1;
        job_bots  = COUNT_W'(n);
        tick();
        job_start = 1'b0;
        repeat (3) tick();
        top_done = 1'b1;
        row_td   = tcyc;
        tick();
        top_done = 1'b0;
    endtask

    typedef struct {
        int n;
        int af_len;
        int exp_writes;
        int exp_top;
    } vec_t;

    vec_t vt[5];

    initial begin
        rst = 1'b0; job_start = 1'b0; job_bots = '0; top_done = 1'b0;
        bot_valid = 1'b0; pipe_almost_full = 1'b0; pipe_result = 1'b0; sink_ready = 1'b1;
`ifdef PERM_JOB_ACCUM_EN
        pcoeff_sum = '0; pcoeff_count = '0;
`endif
        clear_row();

        vt[0] = '{n: 5,  af_len: 0,  exp_writes: 5,  exp_top: 1};
        vt[1] = '{n: 5,  af_len: 20, exp_writes: 5,  exp_top: 1};
        vt[2] = '{n: 1,  af_len: 0,  exp_writes: 1,  exp_top: 1};
        vt[3] = '{n: 0,  af_len: 0,  exp_writes: 0,  exp_top: 0};
        vt[4] = '{n: 12, af_len: 6,  exp_writes: 12, exp_top: 1};

        // reset state
        repeat (2) tick();
        chk_en = 1;
        tick();
        rst = 1'b1;
        check("reset_job_ready", job_ready, 1'b1);
        check("reset_error", error, 1'b0);
        check("reset_outstanding", outstanding, '0);

        // table-driven job scenarios
        for (int i = 0; i < 5; i++) begin
            int af_cnt;
            int guard;
            af_cnt = 0;
            guard = 0;
            clear_row();
            sink_ready = (i % 2) == 0;
            start_job(vt[i].n);
            bot_valid = 1'b1;
            while (row_done == 0 && guard < 400) begin
                pipe_almost_full = (vt[i].af_len > 0) && (row_w >= 2) && (af_cnt < vt[i].af_len);
                if (pipe_almost_full) af_cnt++;
                pipe_result = ((m_w - m_r) > 0) && ($urandom_range(1, 0) == 1);
                tick();
                guard++;
            end
            bot_valid = 1'b0; pipe_almost_full = 1'b0; pipe_result = 1'b0;
            tick();
            check($sformatf("row%0d_done", i), 64'(row_done), 64'd1);
            check($sformatf("row%0d_writes", i), 64'(row_w), 64'(vt[i].exp_writes));
            check($sformatf("row%0d_top", i), 64'(row_top), 64'(vt[i].exp_top));
            check($sformatf("row%0d_af_writes", i), 64'(row_afw), 64'd0);
            if (vt[i].n > 0)
                check($sformatf("row%0d_latency", i), 64'(row_fw - row_td), 64'(SETTLE + 1));
        end
        sink_ready = 1'b1;

        // credit limit: results withheld, stall at MAXO, each result frees one write
        clear_row();
        start_job(10);
        bot_valid = 1'b1;
        repeat (30) tick();
        check("credit_stall_outstanding", outstanding, 64'(MAXO));
        check("credit_stall_writes", 64'(row_w), 64'(MAXO));
        bot_valid = 1'b0; pipe_result = 1'b1; tick();
        pipe_result = 1'b0; tick();
        check("credit_drop_outstanding", outstanding, 64'd3);
        // simultaneous write and result at outstanding 3
        bot_valid = 1'b1; pipe_result = 1'b1; tick();
        bot_valid = 1'b0; pipe_result = 1'b0; tick();
        check("same_cycle_outstanding", outstanding, 64'd3);
        check("same_cycle_writes", 64'(row_w), 64'd5);
        bot_valid = 1'b1; tick(); tick();
        for (int i = 0; i < 4; i++) begin
            pipe_result = 1'b1; tick();
            pipe_result = 1'b0; tick(); tick();
            check($sformatf("release%0d_writes", i), 64'(row_w), 64'(7 + i));
            check($sformatf("release%0d_outstanding", i), outstanding, 64'(MAXO));
        end
        bot_valid = 1'b0;
        pipe_result = 1'b1; repeat (4) tick();
        pipe_result = 1'b0;
        for (int g = 0; g < 20 && row_done == 0; g++) tick();
        check("credit_job_done", 64'(row_done), 64'd1);
        tick();

        // stray result in IDLE sets sticky error; one reset cycle clears it
        pipe_result = 1'b1; tick();
        pipe_result = 1'b0; tick();
        check("idle_result_error", error, 1'b1);
        repeat (5) tick();
        check("error_sticky", error, 1'b1);
        rst = 1'b0; tick();
        rst = 1'b1;
        check("error_cleared", error, 1'b0);
        check("ready_after_reset", job_ready, 1'b1);
        tick();

`ifdef PERM_JOB_ACCUM_EN
        // accumulator over three results
        clear_row();
        start_job(3);
        bot_valid = 1'b1;
        repeat (15) tick();
        bot_valid = 1'b0;
        pipe_result = 1'b1;
        pcoeff_sum = 48'd10;   pcoeff_count = 13'd1; tick();
        pcoeff_sum = 48'd20;   pcoeff_count = 13'd2; tick();
        pcoeff_sum = 48'd4096; pcoeff_count = 13'd3; tick();
        pipe_result = 1'b0; pcoeff_sum = '0; pcoeff_count = '0;
        for (int g = 0; g < 20 && row_done == 0; g++) tick();
        check("accum_done", 64'(row_done), 64'd1);
        check("accum_sum", done_sum, 64'd4126);
        check("accum_count", 64'(done_cnt), 64'd6);
        tick();
`endif

        // randomized phase, including job_start outside IDLE and rare resets
        for (int k = 0; k < 3000; k++) begin
`ifdef PERM_JOB_ACCUM_EN
            logic [63:0] rv;
            rv = {$urandom, $urandom};
            pcoeff_sum   = rv[47:0];
            pcoeff_count = rv[60:48];
`endif
            rst              = ($urandom_range(399, 0) != 0);
            job_start        = ($urandom_range(7, 0) == 0);
            job_bots         = COUNT_W'($urandom_range(7, 0));
            top_done         = ($urandom_range(3, 0) == 0);
            bot_valid        = ($urandom_range(3, 0) != 0);
            pipe_almost_full = ($urandom_range(4, 0) == 0);
            sink_ready       = ($urandom_range(1, 0) == 1);
            pipe_result      = ((m_w - m_r) > 0) && ($urandom_range(2, 0) != 0);
            tick();
        end
        rst = 1'b1; job_start = 1'b0; top_done = 1'b0; bot_valid = 1'b0;
        pipe_almost_full = 1'b0; pipe_result = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
